// File: rtl/sq_pkg.sv
// ---------------------------------------------------------------------------
// sq_pkg : shared widths, state encoding and word types for column resolution
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sq_pkg;

  localparam int COL_BITS   = 23;
  localparam int DIGIT_BITS = 16;
  localparam int CARRY_BITS = 9;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef logic [COL_BITS-1:0]   col_word_t;
  typedef logic [DIGIT_BITS-1:0] digit_t;

endpackage

`default_nettype wire

// File: rtl/column_carry_resolve_col_sum3.sv
// ---------------------------------------------------------------------------
// col_sum3 : combinational a + b + cin, two bits wider than the operands
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module col_sum3 #(
  parameter int W  = 23,
  parameter int CW = 9
) (
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [CW-1:0] cin_i,
  output logic [W+1:0]  sum_o
);

  // Everything is widened before adding so no carry out is lost.
  assign sum_o = (W+2)'(a_i) + (W+2)'(b_i) + (W+2)'(cin_i);

endmodule

`default_nettype wire

// File: rtl/column_carry_resolve.sv
// ---------------------------------------------------------------------------
// column_carry_resolve : folds carry-save column pairs into 16-bit digits,
// chaining the carry across columns and flushing it as a final digit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module column_carry_resolve
  import sq_pkg::*;
(
  input  logic            clk_sq,
  input  logic            reset_sq,
  input  logic            col_valid,
  output logic            col_ready,
  input  col_word_t       col_c,
  input  col_word_t       col_s,
  input  logic            col_first,
  input  logic            col_last,
  output logic            dig_valid,
  input  logic            dig_ready,
  output digit_t          dig_data,
  output logic            dig_last,
  output logic [7:0]      dig_index,
  output logic            proto_err
);

  state_e                  state_q;
  logic [CARRY_BITS-1:0]   carry_q;
  logic                    open_q;
  logic                    proto_err_q;
  logic                    dig_valid_q;
  digit_t                  dig_data_q;
  logic                    dig_last_q;
  logic [7:0]              dig_index_q;

  logic [CARRY_BITS-1:0]   cin;
  logic [COL_BITS+1:0]     sum;
  logic                    out_free;
  logic                    accept;
  logic                    seq_err;
  digit_t                  digit_d;
  logic [CARRY_BITS-1:0]   carry_d;
  logic [7:0]              index_d;

  assign cin = col_first ? '0 : carry_q;

  col_sum3 #(
    .W  (COL_BITS),
    .CW (CARRY_BITS)
  ) u_sum (
    .a_i   (col_c),
    .b_i   (col_s),
    .cin_i (cin),
    .sum_o (sum)
  );

  assign out_free  = !dig_valid_q || dig_ready;
  assign col_ready = (state_q == RUN) && out_free;
  assign accept    = col_valid && col_ready;

  // A first column must start a fresh operand; any other column must continue one.
  assign seq_err = col_first ? open_q : !open_q;

  assign digit_d = sum[DIGIT_BITS-1:0];
  assign carry_d = sum[DIGIT_BITS +: CARRY_BITS];
  assign index_d = col_first ? 8'd0 : dig_index_q + 8'd1;

  always_ff @(posedge clk_sq) begin
    if (!reset_sq) begin
      state_q     <= RUN;
      carry_q     <= '0;
      open_q      <= 1'b0;
      proto_err_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      dig_last_q  <= 1'b0;
      dig_index_q <= 8'd0;
    end else begin
      if (dig_valid_q && dig_ready) begin
        dig_valid_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (accept) begin
            dig_valid_q <= 1'b1;
            dig_data_q  <= digit_d;
            dig_last_q  <= 1'b0;
            dig_index_q <= index_d;
            carry_q     <= carry_d;
            if (seq_err) begin
              proto_err_q <= 1'b1;
            end
            if (col_last) begin
              state_q <= FLUSH;
              open_q  <= 1'b0;
            end else begin
              open_q  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            dig_valid_q <= 1'b1;
            dig_data_q  <= DIGIT_BITS'(carry_q);
            dig_last_q  <= 1'b1;
            dig_index_q <= dig_index_q + 8'd1;
            carry_q     <= '0;
            state_q     <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign dig_valid = dig_valid_q;
  assign dig_data  = dig_data_q;
  assign dig_last  = dig_last_q;
  assign dig_index = dig_index_q;
  assign proto_err = proto_err_q;

endmodule

`default_nettype wire
